// File: rtl/alu_serial_ctrl_if.sv
// ============================================================================
// alu_serial_ctrl_if
// Request/response bundle for the bit-serial ALU sequencer.
//
// Signals:
//   Start    request pulse; accepted only when the sequencer is not running
//   Sel      op select: 00 AND, 01 OR, 1x add/sub
//   InvertB  1 = subtract (B inverted, carry-in 1); ignored for AND/OR
//   DataA/B  operands, latched on an accepted Start
//   Busy     high while an operation is in progress
//   Done     one-cycle completion pulse; Result/Cout/Zero valid
//   Result   result word
//   Cout     carry out of the MSB (0 for AND/OR)
//   Zero     Result == 0
//   Overflow signed overflow for add/sub (only with ALU_SERIAL_OVF_EN)
//
// Modports: master = requester, slave = sequencer.
// Optional feature macro: ALU_SERIAL_OVF_EN
// ============================================================================
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [1:0]       Sel;
    logic             InvertB;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             Overflow;
`endif

    // Requester side: drives the operation, observes status and result.
    modport master (
        output Start,
        output Sel,
        output InvertB,
        output DataA,
        output DataB,
        input  Busy,
        input  Done,
        input  Result,
        input  Cout,
`ifdef ALU_SERIAL_OVF_EN
        input  Overflow,
`endif
        input  Zero
    );

    // Sequencer side.
    modport slave (
        input  Start,
        input  Sel,
        input  InvertB,
        input  DataA,
        input  DataB,
        output Busy,
        output Done,
        output Result,
        output Cout,
`ifdef ALU_SERIAL_OVF_EN
        output Overflow,
`endif
        output Zero
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
// alu_serial_ctrl
// Bit-serial ALU sequencer. One 1-bit ALU slice (AND / OR / ADD / SUB) is
// time-multiplexed over a WIDTH-bit operand pair, one bit per clock, LSB
// first. Owns the carry flip-flop, operand/result shift registers, the bit
// counter and the Start/Done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_serial_ctrl_if.slave (Start/Sel/InvertB/DataA/DataB in,
//          Busy/Done/Result/Cout/Zero[/Overflow] out, all registered)
//
// Parameters:
//   WIDTH  operand/result width, 2..64
//   CNT_W  bit-counter width, 2**CNT_W >= WIDTH
//
// Optional feature macro: ALU_SERIAL_OVF_EN adds the Overflow output
// (carry-into-MSB XOR carry-out, add/sub only).
// ============================================================================
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_serial_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_sel_q;
    logic               op_inv_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               zero_q;
`ifdef ALU_SERIAL_OVF_EN
    logic               ovf_q;
`endif

    // 1-bit ALU slice operating on the current LSBs and the carry flip-flop.
    logic slice_a_c;
    logic slice_b_c;
    logic slice_out_c;
    logic slice_cout_c;

    always_comb begin
        slice_a_c    = sa_q[0];
        // B is inverted only on the arithmetic path.
        slice_b_c    = sb_q[0] ^ (op_sel_q[1] & op_inv_q);
        slice_cout_c = (slice_a_c & slice_b_c) | (slice_a_c & carry_q) |
                       (slice_b_c & carry_q);
        unique case (op_sel_q)
            2'b00:   slice_out_c = slice_a_c & slice_b_c;
            2'b01:   slice_out_c = slice_a_c | slice_b_c;
            default: slice_out_c = slice_a_c ^ slice_b_c ^ carry_q;
        endcase
    end

    // Shifted next values used during RUN.
    logic [WIDTH-1:0] sa_d;
    logic [WIDTH-1:0] sb_d;
    logic [WIDTH-1:0] res_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_bit_c;

    always_comb begin
        sa_d       = {1'b0, sa_q[WIDTH-1:1]};
        sb_d       = {1'b0, sb_q[WIDTH-1:1]};
        res_d      = {slice_out_c, res_q[WIDTH-1:1]};
        cnt_d      = cnt_q + CNT_W'(1);
        last_bit_c = (cnt_q == LAST_BIT);
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            op_sel_q <= 2'b00;
            op_inv_q <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            // Done is a single-cycle pulse unless re-asserted below.
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.Start) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        sa_q     <= bus.DataA;
                        sb_q     <= bus.DataB;
                        op_sel_q <= bus.Sel;
                        op_inv_q <= bus.InvertB;
                        // Carry-in of 1 turns A + ~B into A - B.
                        carry_q  <= bus.Sel[1] & bus.InvertB;
                        cnt_q    <= '0;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_q    <= sa_d;
                    sb_q    <= sb_d;
                    res_q   <= res_d;
                    carry_q <= slice_cout_c;
                    cnt_q   <= cnt_d;
                    if (last_bit_c) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= op_sel_q[1] & slice_cout_c;
                        zero_q  <= (res_d == '0);
`ifdef ALU_SERIAL_OVF_EN
                        // carry_q here is the carry into the MSB.
                        ovf_q   <= op_sel_q[1] & (carry_q ^ slice_cout_c);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Result   = res_q;
    assign bus.Cout     = cout_q;
    assign bus.Zero     = zero_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
// tb_alu_serial_ctrl
// Self-checking bench for alu_serial_ctrl at WIDTH=8. A word-level model
// predicts when Busy/Done must be seen and what each operation produces;
// a compare process checks the DUT against it every cycle, and directed
// cases pin literal values. Optional macro: ALU_SERIAL_OVF_EN.
// ============================================================================
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level reference model ----------------
    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } outcome_t;

    function automatic outcome_t calc(input logic [1:0] sel, input logic inv,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
        outcome_t o;
        logic [W-1:0] bb;
        logic [W:0]   sum;
        o.cout = 1'b0;
        o.ovf  = 1'b0;
        case (sel)
            2'b00:   o.res = a & b;
            2'b01:   o.res = a | b;
            default: begin
                bb     = inv ? ~b : b;
                sum    = {1'b0, a} + {1'b0, bb} + (W+1)'(inv);
                o.res  = sum[W-1:0];
                o.cout = sum[W];
                o.ovf  = (a[W-1] == bb[W-1]) && (o.res[W-1] != a[W-1]);
            end
        endcase
        o.zero = (o.res == '0);
        return o;
    endfunction

    int       m_edge;      // index of the next rising edge
    int       m_acc;       // edge index that accepted the current operation
    logic     m_active;
    outcome_t m_pend;
    outcome_t m_held;

    // An op accepted at edge n runs for edges n..n+7, completes at n+8,
    // and a new Start is next accepted from edge n+9 onward.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge   <= 0;
            m_acc    <= 0;
            m_active <= 1'b0;
            m_pend   <= '{default: '0};
            m_held   <= '{default: '0};
        end else begin
            m_edge <= m_edge + 1;
            if (m_active && (m_edge - m_acc == W))
                m_held <= m_pend;
            if (bus.Start && (!m_active || (m_edge - m_acc > W))) begin
                m_acc    <= m_edge;
                m_active <= 1'b1;
                m_pend   <= calc(bus.Sel, bus.InvertB, bus.DataA, bus.DataB);
            end
        end
    end

    // Compare DUT against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int  d;
            logic e_busy, e_done;
            d      = m_edge - 1 - m_acc;
            e_busy = m_active && (d >= 0) && (d < W);
            e_done = m_active && (d == W);
            chk("Busy", 64'(bus.Busy), 64'(e_busy));
            chk("Done", 64'(bus.Done), 64'(e_done));
            if (!e_busy) begin
                chk("Result", 64'(bus.Result), 64'(m_held.res));
                chk("Cout",   64'(bus.Cout),   64'(m_held.cout));
                chk("Zero",   64'(bus.Zero),   64'(m_held.zero));
`ifdef ALU_SERIAL_OVF_EN
                chk("Overflow", 64'(bus.Overflow), 64'(m_held.ovf));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] sel, input logic inv,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Sel     = sel;
        bus.InvertB = inv;
        bus.DataA   = a;
        bus.DataB   = b;
    endtask

    // From the negedge just after the accepting edge, count cycles to Done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = (bus.Busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.Busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] sel, input logic inv,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ez);
        int lat, bc;
        drive(sel, inv, a, b);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done(lat, bc);
        chk({tag, " latency"}, 64'(lat), 64'(W));
        chk({tag, " busy cycles"}, 64'(bc), 64'(W));
        chk({tag, " Result"}, 64'(bus.Result), 64'(er));
        chk({tag, " Cout"}, 64'(bus.Cout), 64'(ec));
        chk({tag, " Zero"}, 64'(bus.Zero), 64'(ez));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, bc;
        rst_n = 1'b0;
        bus.Start = 1'b0;
        drive(2'b00, 1'b0, '0, '0);
        #12;
        chk("reset Busy",   64'(bus.Busy),   64'd0);
        chk("reset Done",   64'(bus.Done),   64'd0);
        chk("reset Result", 64'(bus.Result), 64'd0);
        chk("reset Cout",   64'(bus.Cout),   64'd0);
        chk("reset Zero",   64'(bus.Zero),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases with hand-computed results.
        run_op("add 3C+0F", 2'b10, 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
        run_op("sub 05-07", 2'b10, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
`ifdef ALU_SERIAL_OVF_EN
        chk("sub 05-07 Overflow", 64'(bus.Overflow), 64'd0);
`endif
        repeat (3) @(negedge clk);
        run_op("and F0&3C", 2'b00, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        // Issued in the Done cycle: back-to-back acceptance.
        run_op("or F0|3C b2b", 2'b01, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_op("add FF+01", 2'b10, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("sub 09-09", 2'b11, 1'b1, 8'h09, 8'h09, 8'h00, 1'b1, 1'b1);
        run_op("and ignores inv", 2'b00, 1'b1, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0);
`ifdef ALU_SERIAL_OVF_EN
        run_op("add 7F+01", 2'b10, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
        chk("add 7F+01 Overflow", 64'(bus.Overflow), 64'd1);
`endif
        repeat (2) @(negedge clk);

        // Start during RUN must be ignored.
        drive(2'b10, 1'b0, 8'h12, 8'h34);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        drive(2'b01, 1'b0, 8'hFF, 8'hFF);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done(lat, bc);
        chk("ignored start latency", 64'(lat), 64'd4);
        chk("ignored start Result", 64'(bus.Result), 64'h46);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        drive(2'b10, 1'b0, 8'h55, 8'h22);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset Busy",   64'(bus.Busy),   64'd0);
        chk("midrun reset Done",   64'(bus.Done),   64'd0);
        chk("midrun reset Result", 64'(bus.Result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("add 01+01 after reset", 2'b10, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        // Random traffic with sparse Start pulses.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(3)), 1'($urandom_range(1)),
                  W'($urandom), W'($urandom));
            bus.Start = ($urandom_range(3) == 0);
            @(negedge clk);
        end
        // Start held high: back-to-back ops, ignored requests during RUN.
        bus.Start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom_range(3)), 1'($urandom_range(1)),
                  W'($urandom), W'($urandom));
            @(negedge clk);
        end
        bus.Start = 1'b0;
        repeat (2 * W) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
